branch_resolve: RTL and testbench

EX-stage counterpart of the IF-stage 2-bit branch predictor. It carries each fetched instruction's prediction down a PIPE_DEPTH-entry shadow pipeline and compares the prediction against the actual outcome at EX. It drives the predictor's training inputs (`branch`, `branch_taken`). On a misprediction it issues a corrected PC redirect to IF and a multi-cycle flush of the younger stages.

---
 rtl/branch_resolve_if.sv | 34 +++
 rtl/branch_resolve.sv | 142 ++++++++++++++
 tb/tb_branch_resolve.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/branch_resolve_if.sv
// rtl/branch_resolve_if.sv - IF/EX/predictor-training signal bundle for branch_resolve
interface branch_resolve_if #(
    parameter int CNT_W = 16
);
    logic              if_valid;
    logic              if_branch;
    logic              if_pred_taken;
    logic [31:0]       if_pc;
    logic              stall;
    logic              ex_branch;
    logic              ex_taken;
    logic [31:0]       ex_target;
    logic              upd_valid;
    logic              upd_taken;
    logic              redirect_valid;
    logic [31:0]       redirect_pc;
    logic              flush;
    logic [CNT_W-1:0]  branch_cnt;
    logic [CNT_W-1:0]  mispredict_cnt;

    modport master (
        output if_valid, if_branch, if_pred_taken, if_pc, stall,
               ex_branch, ex_taken, ex_target,
        input  upd_valid, upd_taken, redirect_valid, redirect_pc, flush,
               branch_cnt, mispredict_cnt
    );

    modport slave (
        input  if_valid, if_branch, if_pred_taken, if_pc, stall,
               ex_branch, ex_taken, ex_target,
        output upd_valid, upd_taken, redirect_valid, redirect_pc, flush,
               branch_cnt, mispredict_cnt
    );
endinterface

// File: rtl/branch_resolve.sv
// rtl/branch_resolve.sv - EX-stage branch resolution, predictor training, redirect and flush
// Optional statistics counters are enabled by defining BRANCH_STATS_EN.
module branch_resolve #(
    parameter int PIPE_DEPTH   = 2,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    branch_resolve_if.slave  bus
);
    localparam int FCW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [FCW-1:0] FLUSH_INIT = FCW'(FLUSH_CYCLES - 1);

    typedef enum logic {IDLE, FLUSH} state_t;

    typedef struct packed {
        logic        valid;
        logic        branch;
        logic        pred_taken;
        logic [31:0] pc;
    } shadow_t;

    state_t          state;
    logic [FCW-1:0]  flush_cnt;
    shadow_t         sh [PIPE_DEPTH];
    shadow_t         entry_in;
    shadow_t         tail;

    logic            upd_valid_r;
    logic            upd_taken_r;
    logic            redirect_valid_r;
    logic [31:0]     redirect_pc_r;
    logic            flush_r;

    logic            predicted;
    logic            resolve;
    logic            mispredict;
    logic [31:0]     correct_pc;

    assign tail = sh[PIPE_DEPTH-1];

    // While flushing, anything fetched is on the wrong path and enters as a bubble.
    always_comb begin
        entry_in            = '0;
        entry_in.valid      = bus.if_valid & (state == IDLE);
        entry_in.branch     = bus.if_branch & bus.if_valid & (state == IDLE);
        entry_in.pred_taken = bus.if_pred_taken;
        entry_in.pc         = bus.if_pc;
    end

    assign predicted  = tail.valid & tail.branch & tail.pred_taken;
    assign resolve    = ~bus.stall & (state == IDLE) & bus.ex_branch;
    assign mispredict = resolve & (bus.ex_taken != predicted);
    assign correct_pc = bus.ex_taken ? bus.ex_target : (tail.pc + 32'd4);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            flush_cnt        <= '0;
            upd_valid_r      <= 1'b0;
            upd_taken_r      <= 1'b0;
            redirect_valid_r <= 1'b0;
            redirect_pc_r    <= '0;
            flush_r          <= 1'b0;
            for (int i = 0; i < PIPE_DEPTH; i++) begin
                sh[i] <= '0;
            end
        end else begin
            upd_valid_r      <= 1'b0;
            redirect_valid_r <= 1'b0;

            if (!bus.stall) begin
                for (int i = PIPE_DEPTH - 1; i > 0; i--) begin
                    sh[i] <= sh[i-1];
                end
                sh[0] <= entry_in;
            end

            case (state)
                IDLE: begin
                    if (resolve) begin
                        upd_valid_r <= 1'b1;
                        upd_taken_r <= bus.ex_taken;
                        if (mispredict) begin
                            redirect_valid_r <= 1'b1;
                            redirect_pc_r    <= correct_pc;
                            flush_r          <= 1'b1;
                            flush_cnt        <= FLUSH_INIT;
                            state            <= FLUSH;
                            // Kill every in-flight shadow entry, including the one just shifted in.
                            for (int i = 0; i < PIPE_DEPTH; i++) begin
                                sh[i].valid <= 1'b0;
                            end
                        end
                    end
                end
                FLUSH: begin
                    if (flush_cnt == '0) begin
                        flush_r <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        flush_cnt <= flush_cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.upd_valid      = upd_valid_r;
    assign bus.upd_taken      = upd_taken_r;
    assign bus.redirect_valid = redirect_valid_r;
    assign bus.redirect_pc    = redirect_pc_r;
    assign bus.flush          = flush_r;

`ifdef BRANCH_STATS_EN
    logic [CNT_W-1:0] branch_cnt_r;
    logic [CNT_W-1:0] mispredict_cnt_r;

    // Saturating counters: they stick at all-ones rather than wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            branch_cnt_r     <= '0;
            mispredict_cnt_r <= '0;
        end else begin
            if (resolve && !(&branch_cnt_r)) begin
                branch_cnt_r <= branch_cnt_r + 1'b1;
            end
            if (mispredict && !(&mispredict_cnt_r)) begin
                mispredict_cnt_r <= mispredict_cnt_r + 1'b1;
            end
        end
    end

    assign bus.branch_cnt     = branch_cnt_r;
    assign bus.mispredict_cnt = mispredict_cnt_r;
`else
    assign bus.branch_cnt     = '0;
    assign bus.mispredict_cnt = '0;
`endif
endmodule

// File: tb/tb_branch_resolve.sv
// tb/tb_branch_resolve.sv - directed self-checking bench for branch_resolve
module tb_branch_resolve;
    localparam int CW = 4;
`ifdef BRANCH_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic clk;
    logic rst;
    int   compared   = 0;
    int   mismatched = 0;

    branch_resolve_if #(.CNT_W(CW)) bus ();

    branch_resolve #(
        .PIPE_DEPTH  (2),
        .FLUSH_CYCLES(2),
        .CNT_W       (CW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] pc, input logic pred);
        bus.if_valid      = 1'b1;
        bus.if_branch     = 1'b1;
        bus.if_pred_taken = pred;
        bus.if_pc         = pc;
        tick();
        bus.if_valid      = 1'b0;
        bus.if_branch     = 1'b0;
        bus.if_pred_taken = 1'b0;
        tick();
    endtask

    task automatic resolve_at_ex(input logic taken, input logic [31:0] target);
        bus.ex_branch = 1'b1;
        bus.ex_taken  = taken;
        bus.ex_target = target;
        tick();
        bus.ex_branch = 1'b0;
        bus.ex_taken  = 1'b0;
    endtask

    initial begin
        rst               = 1'b1;
        bus.if_valid      = 1'b0;
        bus.if_branch     = 1'b0;
        bus.if_pred_taken = 1'b0;
        bus.if_pc         = 32'h0;
        bus.stall         = 1'b0;
        bus.ex_branch     = 1'b0;
        bus.ex_taken      = 1'b0;
        bus.ex_target     = 32'h0;
        tick();
        tick();
        rst = 1'b0;

        repeat (5) tick();
        chk("idle_upd_valid", bus.upd_valid, 1'b0);
        chk("idle_upd_taken", bus.upd_taken, 1'b0);
        chk("idle_redirect_valid", bus.redirect_valid, 1'b0);
        chk("idle_redirect_pc", bus.redirect_pc, 32'h0);
        chk("idle_flush", bus.flush, 1'b0);
        chk("idle_branch_cnt", bus.branch_cnt, 4'd0);
        chk("idle_mispredict_cnt", bus.mispredict_cnt, 4'd0);

        issue(32'h100, 1'b0);
        resolve_at_ex(1'b0, 32'h0);
        chk("nt_ok_upd_valid", bus.upd_valid, 1'b1);
        chk("nt_ok_upd_taken", bus.upd_taken, 1'b0);
        chk("nt_ok_redirect_valid", bus.redirect_valid, 1'b0);
        chk("nt_ok_flush", bus.flush, 1'b0);
        tick();
        chk("nt_ok_upd_pulse_end", bus.upd_valid, 1'b0);

        issue(32'h200, 1'b0);
        resolve_at_ex(1'b1, 32'h240);
        chk("mp_upd_valid", bus.upd_valid, 1'b1);
        chk("mp_upd_taken", bus.upd_taken, 1'b1);
        chk("mp_redirect_valid", bus.redirect_valid, 1'b1);
        chk("mp_redirect_pc", bus.redirect_pc, 32'h240);
        chk("mp_flush_c1", bus.flush, 1'b1);
        bus.ex_branch = 1'b1;
        bus.ex_taken  = 1'b1;
        bus.ex_target = 32'h999;
        tick();
        chk("mp_flush_c2", bus.flush, 1'b1);
        chk("mp_masked_upd", bus.upd_valid, 1'b0);
        chk("mp_redirect_pulse_end", bus.redirect_valid, 1'b0);
        chk("mp_redirect_pc_held", bus.redirect_pc, 32'h240);
        tick();
        chk("mp_flush_end", bus.flush, 1'b0);
        chk("mp_masked_upd2", bus.upd_valid, 1'b0);
        bus.ex_branch = 1'b0;
        bus.ex_taken  = 1'b0;
        tick();
        chk("mp_flush_stays_low", bus.flush, 1'b0);

        issue(32'hFFFF_FFFC, 1'b1);
        resolve_at_ex(1'b0, 32'h1234);
        chk("wrap_redirect_valid", bus.redirect_valid, 1'b1);
        chk("wrap_redirect_pc", bus.redirect_pc, 32'h0);
        chk("wrap_upd_taken", bus.upd_taken, 1'b0);
        chk("wrap_flush_c1", bus.flush, 1'b1);
        tick();
        chk("wrap_flush_c2", bus.flush, 1'b1);
        tick();
        chk("wrap_flush_end", bus.flush, 1'b0);

        issue(32'h300, 1'b1);
        resolve_at_ex(1'b1, 32'h400);
        chk("t_ok_upd_valid", bus.upd_valid, 1'b1);
        chk("t_ok_upd_taken", bus.upd_taken, 1'b1);
        chk("t_ok_redirect_valid", bus.redirect_valid, 1'b0);
        chk("t_ok_redirect_pc_held", bus.redirect_pc, 32'h0);
        chk("t_ok_flush", bus.flush, 1'b0);

        bus.if_valid      = 1'b1;
        bus.if_branch     = 1'b1;
        bus.if_pred_taken = 1'b0;
        bus.if_pc         = 32'h500;
        tick();
        bus.if_pred_taken = 1'b1;
        bus.if_pc         = 32'h504;
        tick();
        bus.if_valid      = 1'b0;
        bus.if_branch     = 1'b0;
        bus.if_pred_taken = 1'b0;
        bus.ex_branch     = 1'b1;
        bus.ex_taken      = 1'b0;
        tick();
        chk("b2b_a_upd_valid", bus.upd_valid, 1'b1);
        chk("b2b_a_redirect_valid", bus.redirect_valid, 1'b0);
        tick();
        bus.ex_branch = 1'b0;
        chk("b2b_b_upd_valid", bus.upd_valid, 1'b1);
        chk("b2b_b_redirect_valid", bus.redirect_valid, 1'b1);
        chk("b2b_b_redirect_pc", bus.redirect_pc, 32'h508);
        chk("b2b_b_flush", bus.flush, 1'b1);
        tick();
        tick();
        chk("b2b_flush_end", bus.flush, 1'b0);

        issue(32'h600, 1'b1);
        bus.stall     = 1'b1;
        bus.ex_branch = 1'b1;
        bus.ex_taken  = 1'b1;
        bus.ex_target = 32'h700;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_no_upd", bus.upd_valid, 1'b0);
        end
        bus.stall = 1'b0;
        tick();
        bus.ex_branch = 1'b0;
        bus.ex_taken  = 1'b0;
        chk("stall_release_upd", bus.upd_valid, 1'b1);
        chk("stall_release_taken", bus.upd_taken, 1'b1);
        chk("stall_release_no_redirect", bus.redirect_valid, 1'b0);
        tick();
        chk("stall_single_upd", bus.upd_valid, 1'b0);
        chk("cnt_branch_7", bus.branch_cnt, (STATS ? 4'd7 : 4'd0));
        chk("cnt_mispredict_3", bus.mispredict_cnt, (STATS ? 4'd3 : 4'd0));

        for (int i = 0; i < 20; i++) begin
            resolve_at_ex(1'b1, 32'h800);
            tick();
            tick();
        end
        chk("sat_branch_cnt", bus.branch_cnt, (STATS ? 4'hF : 4'd0));
        chk("sat_mispredict_cnt", bus.mispredict_cnt, (STATS ? 4'hF : 4'd0));
        chk("sat_redirect_pc", bus.redirect_pc, 32'h800);

        resolve_at_ex(1'b1, 32'h900);
        chk("rst_pre_flush", bus.flush, 1'b1);
        rst = 1'b1;
        #1;
        chk("rst_async_flush", bus.flush, 1'b0);
        chk("rst_async_redirect_valid", bus.redirect_valid, 1'b0);
        chk("rst_async_redirect_pc", bus.redirect_pc, 32'h0);
        chk("rst_async_branch_cnt", bus.branch_cnt, 4'd0);
        chk("rst_async_mispredict_cnt", bus.mispredict_cnt, 4'd0);
        tick();
        rst = 1'b0;
        tick();

        resolve_at_ex(1'b0, 32'h0);
        chk("post_rst_upd_valid", bus.upd_valid, 1'b1);
        chk("post_rst_no_flush", bus.flush, 1'b0);
        chk("post_rst_branch_cnt", bus.branch_cnt, (STATS ? 4'd1 : 4'd0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
